// File: rtl/matvec_pkg.sv
// Shared types and width helper for the column-serial matrix-vector multiplier.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } matvec_state_e;

    // Result width that can hold a sum of c products of w_x by w_k signed values.
    function automatic int yw(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c);
    endfunction

endpackage

// File: rtl/matvec_mac_lane.sv
// One signed multiply-accumulate lane. acc presents the running total
// including the product currently on a/b, so the caller can capture the
// final sum on the same edge that the last column is consumed.
module matvec_mac_lane
    import matvec_pkg::*;
#(
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int W_Y = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic signed [W_K-1:0] a,
    input  logic signed [W_X-1:0] b,
    output logic signed [W_Y-1:0] acc
);

    localparam int W_P = W_X + W_K;

    logic signed [W_P-1:0] prod;
    logic signed [W_Y-1:0] acc_q;

    // Full-precision product, sign-extended into the accumulator width.
    assign prod = W_P'(a) * W_P'(b);
    assign acc  = acc_q + W_Y'(prod);

    // Accumulator: cleared at job start, advanced once per enabled column.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc;
        end
    end

endmodule

// File: rtl/matvec_mul_seq.sv
// Column-serial signed matrix-vector multiplier y = K * x using R MAC lanes
// over C cycles. Optional build macro MATVEC_RELU_EN clamps negative results
// to zero at the moment y is written.
//
// Handshakes: a transfer happens on a rising edge where valid & ready & cen
// are all 1. s_ready depends on state only; m_valid and y are registered and
// stay stable until the transfer completes. With cen=0 nothing transfers.
module matvec_mul_seq
    import matvec_pkg::*;
#(
    parameter  int R   = 3,
    parameter  int C   = 3,
    parameter  int W_X = 8,
    parameter  int W_K = 8,
    localparam int W_Y = yw(W_X, W_K, C)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cen,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [R-1:0][C-1:0][W_K-1:0]  k,
    input  logic [C-1:0][W_X-1:0]         x,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [R-1:0][W_Y-1:0]         y,
    output matvec_state_e                 dbg_state
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;

    matvec_state_e                  state_q, state_d;
    logic [CW-1:0]                  col_q, col_d;
    logic [R-1:0][C-1:0][W_K-1:0]   k_q, k_d;
    logic [C-1:0][W_X-1:0]          x_q, x_d;
    logic [R-1:0][W_Y-1:0]          y_q, y_d;
    logic                           m_valid_q, m_valid_d;

    logic                           lane_clr;
    logic                           lane_en;
    logic signed [W_K-1:0]          lane_a   [R];
    logic signed [W_X-1:0]          lane_b;
    logic signed [W_Y-1:0]          lane_acc [R];

    assign s_ready   = (state_q == IDLE);
    assign m_valid   = m_valid_q;
    assign y         = y_q;
    assign dbg_state = state_q;

    // Column mux: feed the current column of the latched operands to every lane.
    always_comb begin
        lane_b = x_q[col_q];
        for (int r = 0; r < R; r++) begin
            lane_a[r] = k_q[r][col_q];
        end
    end

    for (genvar g = 0; g < R; g++) begin : g_lane
        matvec_mac_lane #(
            .W_X (W_X),
            .W_K (W_K),
            .W_Y (W_Y)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .a   (lane_a[g]),
            .b   (lane_b),
            .acc (lane_acc[g])
        );
    end

    // Next-state, counter, operand capture and result write; all gated by cen.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        k_d       = k_q;
        x_d       = x_q;
        y_d       = y_q;
        m_valid_d = m_valid_q;
        lane_clr  = 1'b0;
        lane_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cen && s_valid) begin
                    k_d      = k;
                    x_d      = x;
                    col_d    = '0;
                    lane_clr = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cen) begin
                    lane_en = 1'b1;
                    if (col_q == CW'(C - 1)) begin
                        for (int r = 0; r < R; r++) begin
`ifdef MATVEC_RELU_EN
                            y_d[r] = lane_acc[r][W_Y-1] ? '0 : lane_acc[r];
`else
                            y_d[r] = lane_acc[r];
`endif
                        end
                        m_valid_d = 1'b1;
                        col_d     = '0;
                        state_d   = DONE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (cen && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            k_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            k_q       <= k_d;
            x_q       <= x_d;
            y_q       <= y_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_matvec_mul_seq.sv
// Directed bench for matvec_mul_seq: driver tasks issue jobs and queue the
// hand-computed results; a negedge monitor pops and compares on each output
// transfer.
module tb_matvec_mul_seq;
  import matvec_pkg::*;

  localparam int R   = 3;
  localparam int C   = 3;
  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int W_Y = 18;

  typedef logic [R-1:0][C-1:0][W_K-1:0] kmat_t;
  typedef logic [C-1:0][W_X-1:0]        xvec_t;
  typedef logic [R*W_Y-1:0]             yvec_t;

  logic                         clk;
  logic                         rst;
  logic                         cen;
  logic                         s_valid;
  logic                         s_ready;
  logic [R-1:0][C-1:0][W_K-1:0] k;
  logic [C-1:0][W_X-1:0]        x;
  logic                         m_valid;
  logic                         m_ready;
  logic [R-1:0][W_Y-1:0]        y;
  matvec_state_e                dbg_state;

  int total = 0;
  int bad   = 0;
  logic [R*W_Y-1:0] exp_q[$];

  matvec_mul_seq #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .k         (k),
    .x         (x),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .y         (y),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic kmat_t mk_k(input int t[R][C]);
    kmat_t v;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        v[r][c] = W_K'(t[r][c]);
    return v;
  endfunction

  function automatic xvec_t mk_x(input int t[C]);
    xvec_t v;
    for (int c = 0; c < C; c++) v[c] = W_X'(t[c]);
    return v;
  endfunction

  // Pack hand-computed sums; the clamp mirrors the optional build feature.
  function automatic yvec_t mk_y(input int t[R]);
    yvec_t v;
    int    e;
    for (int r = 0; r < R; r++) begin
`ifdef MATVEC_RELU_EN
      e = (t[r] < 0) ? 0 : t[r];
`else
      e = t[r];
`endif
      v[r*W_Y +: W_Y] = W_Y'(e);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && cen && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL y_unexpected: got %0h expected no result", y);
      end else begin
        check("y", 64'(y), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver: one full job, optional cen gap after the first column,
  // optional back-pressure hold, optional operand change after accept
  task automatic run_job(input kmat_t kv, input xvec_t xv, input yvec_t ey,
                         input int gap, input int hold, input bit perturb);
    int n;
    n = 0;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check("s_ready_idle", 64'(s_ready), 64'(1));
    k       = kv;
    x       = xv;
    s_valid = 1'b1;
    m_ready = (hold == 0);
    exp_q.push_back(ey);
    tick();
    s_valid = 1'b0;
    if (perturb) begin
      k = ~kv;
      x = ~xv;
    end
    check("s_ready_calc", 64'(s_ready), 64'(0));
    n = 0;
    while (!m_valid && n < 60) begin
      tick();
      n++;
      if (n == 1 && gap > 0) begin
        cen = 1'b0;
        repeat (gap) begin
          tick();
          n++;
        end
        cen = 1'b1;
      end
    end
    check("latency", 64'(n), 64'(C + gap));
    if (hold > 0) begin
      repeat (hold) begin
        check("hold_m_valid", 64'(m_valid), 64'(1));
        check("hold_y", 64'(y), 64'(ey));
        check("hold_s_ready", 64'(s_ready), 64'(0));
        tick();
      end
      m_ready = 1'b1;
    end
    tick();
    check("done_to_idle", 64'(dbg_state), 64'(IDLE));
    check("m_valid_clear", 64'(m_valid), 64'(0));
  endtask

  // main sequence
  initial begin
    int kt1[R][C];
    int xt1[C];
    int yt1[R];
    int km[R][C];
    int xm[C];
    int xp[C];
    int ym[R];
    int yn[R];
    int kid[R][C];
    int xid[C];
    int yid[R];
    int k6[R][C];
    int x6[C];
    int y6[R];

    kt1 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    xt1 = '{1, 2, 3};
    yt1 = '{14, 32, 50};
    km  = '{'{-128, -128, -128}, '{-128, -128, -128}, '{-128, -128, -128}};
    xm  = '{-128, -128, -128};
    ym  = '{49152, 49152, 49152};
    xp  = '{127, 127, 127};
    yn  = '{-48768, -48768, -48768};
    kid = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    xid = '{5, -6, 7};
    yid = '{5, -6, 7};
    k6  = '{'{2, -1, 0}, '{0, 3, -2}, '{1, 1, 1}};
    x6  = '{4, 5, -3};
    y6  = '{3, 21, 6};

    rst     = 1'b1;
    cen     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    k       = '0;
    x       = '0;
    repeat (3) tick();
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_y", 64'(y), 64'(0));
    rst = 1'b0;
    tick();

    // basic job
    run_job(mk_k(kt1), mk_x(xt1), mk_y(yt1), 0, 0, 1'b0);
    // extreme negative operands, then mixed-sign extremes
    run_job(mk_k(km), mk_x(xm), mk_y(ym), 0, 0, 1'b0);
    run_job(mk_k(km), mk_x(xp), mk_y(yn), 0, 0, 1'b0);
    // back-pressure for 10 cycles
    run_job(mk_k(kt1), mk_x(xt1), mk_y(yt1), 0, 10, 1'b0);
    // cen low for 4 cycles mid-job
    run_job(mk_k(kt1), mk_x(xt1), mk_y(yt1), 4, 0, 1'b0);

    // reset while col=1: job is dropped
    k       = mk_k(kt1);
    x       = mk_x(xt1);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    check("mid_calc_state", 64'(dbg_state), 64'(CALC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'(0));
    check("midrst_s_ready", 64'(s_ready), 64'(1));
    check("midrst_y", 64'(y), 64'(0));
    run_job(mk_k(kid), mk_x(xid), mk_y(yid), 0, 0, 1'b0);

    // operands change right after accept
    run_job(mk_k(k6), mk_x(x6), mk_y(y6), 0, 0, 1'b1);

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
